// File: rtl/spectrum_frame_buffer_if.sv
// rtl/spectrum_frame_buffer_if.sv - magnitude beat stream from the FFT stage into spectrum_frame_buffer
interface spectrum_frame_buffer_if #(
  parameter int MAG_BITS = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [7:0]          in_bin;
  logic [MAG_BITS-1:0] in_mag;
  logic                in_last;

  modport master (output in_valid, in_bin, in_mag, in_last, input in_ready);
  modport slave  (input in_valid, in_bin, in_mag, in_last, output in_ready);
endinterface

// File: rtl/spectrum_frame_buffer.sv
// rtl/spectrum_frame_buffer.sv - ping-pong spectrum store, swap at vblank; SPECTRUM_PEAK_HOLD_EN adds per-bin peak hold
module spectrum_frame_buffer #(
  parameter int NUM_BINS  = 256,
  parameter int MAG_BITS  = 16,
  parameter int DATA_BITS = 9,
  parameter int MAG_SHIFT = 7,
  parameter int MAX_VALUE = 440,
  parameter int DECAY     = 4
) (
  input  logic                     clk_pixel,
  input  logic                     rst,
  spectrum_frame_buffer_if.slave   in_if,
  input  logic                     vblank_start,
  input  logic [7:0]               rd_addr,
  output logic [DATA_BITS-1:0]     rd_data,
  output logic                     swap_pulse
);

  localparam logic [8:0]          BIN_LIMIT = 9'(NUM_BINS);
  localparam logic [MAG_BITS-1:0] MAG_CEIL  = MAG_BITS'(MAX_VALUE);

  // Bin addresses are 8 bits wide, and the decay must fit in a stored value
  if (NUM_BINS < 1 || NUM_BINS > 256 || DECAY < 0 || DECAY >= (1 << DATA_BITS)) begin : g_param_check
    $error("spectrum_frame_buffer: parameter out of range");
  end

  typedef enum logic [1:0] {ST_ACCEPT, ST_DRAIN, ST_FULL} wr_state_t;

  wr_state_t state;
  logic      disp_bank;
  logic      shown;
  logic      in_ready_q;
  logic      accept;

  logic [DATA_BITS-1:0] bank0 [NUM_BINS];
  logic [DATA_BITS-1:0] bank1 [NUM_BINS];

  logic [MAG_BITS-1:0]  mag_shifted;
  logic [DATA_BITS-1:0] scaled;

  // Accepted-beat register (first pipeline stage)
  logic                 a_valid;
  logic                 a_in_range;
  logic                 a_last;
  logic [7:0]           a_addr;
  logic [DATA_BITS-1:0] a_scaled;

  // Commit stage seen by the back bank and the FSM
  logic                 c_valid;
  logic                 c_in_range;
  logic                 c_last;
  logic [7:0]           c_addr;
  logic [DATA_BITS-1:0] c_data;

  assign in_if.in_ready = in_ready_q;
  assign accept         = in_if.in_valid & in_ready_q;

  // Scale the magnitude down and clamp it to the plot height
  always_comb begin
    mag_shifted = in_if.in_mag >> MAG_SHIFT;
    scaled      = '0;
    if (mag_shifted > MAG_CEIL) begin
      scaled = DATA_BITS'(MAG_CEIL);
    end else begin
      scaled = DATA_BITS'(mag_shifted);
    end
  end

  // Capture accepted beats; reset drops anything still in flight
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      a_valid    <= 1'b0;
      a_in_range <= 1'b0;
      a_last     <= 1'b0;
      a_addr     <= '0;
      a_scaled   <= '0;
    end else begin
      a_valid    <= accept;
      a_in_range <= ({1'b0, in_if.in_bin} < BIN_LIMIT);
      a_last     <= in_if.in_last;
      a_addr     <= in_if.in_bin;
      a_scaled   <= scaled;
    end
  end

`ifdef SPECTRUM_PEAK_HOLD_EN
  localparam logic [DATA_BITS-1:0] DECAY_W = DATA_BITS'(DECAY);

  logic [DATA_BITS-1:0] hold_mem [NUM_BINS];
  logic [NUM_BINS-1:0]  hold_seen;

  logic                 b_valid;
  logic                 b_in_range;
  logic                 b_last;
  logic [7:0]           b_addr;
  logic [DATA_BITS-1:0] b_scaled;
  logic [DATA_BITS-1:0] b_hold;
  logic [DATA_BITS-1:0] b_decayed;
  logic [DATA_BITS-1:0] b_value;

  // Hold lookup; a same-bin beat right behind takes the value being written now
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      b_valid    <= 1'b0;
      b_in_range <= 1'b0;
      b_last     <= 1'b0;
      b_addr     <= '0;
      b_scaled   <= '0;
      b_hold     <= '0;
    end else begin
      b_valid    <= a_valid;
      b_in_range <= a_in_range;
      b_last     <= a_last;
      b_addr     <= a_addr;
      b_scaled   <= a_scaled;
      if (b_valid && b_in_range && (b_addr == a_addr)) begin
        b_hold <= b_value;
      end else if (a_in_range && hold_seen[a_addr]) begin
        b_hold <= hold_mem[a_addr];
      end else begin
        b_hold <= '0;
      end
    end
  end

  // New peak: the larger of the fresh value and the decayed previous peak
  always_comb begin
    b_decayed = (b_hold > DECAY_W) ? (b_hold - DECAY_W) : '0;
    b_value   = (b_scaled > b_decayed) ? b_scaled : b_decayed;
  end

  // Hold RAM update; contents survive reset, the seen mask gates them
  always_ff @(posedge clk_pixel) begin
    if (b_valid && b_in_range) begin
      hold_mem[b_addr] <= b_value;
    end
  end

  // Mark bins whose hold entry holds a real value
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      hold_seen <= '0;
    end else if (b_valid && b_in_range) begin
      hold_seen[b_addr] <= 1'b1;
    end
  end

  assign c_valid    = b_valid;
  assign c_in_range = b_in_range;
  assign c_last     = b_last;
  assign c_addr     = b_addr;
  assign c_data     = b_value;
`else
  assign c_valid    = a_valid;
  assign c_in_range = a_in_range;
  assign c_last     = a_last;
  assign c_addr     = a_addr;
  assign c_data     = a_scaled;
`endif

  // Commit into the back bank; out-of-range bins are silently dropped
  always_ff @(posedge clk_pixel) begin
    if (c_valid && c_in_range) begin
      if (disp_bank) begin
        bank0[c_addr] <= c_data;
      end else begin
        bank1[c_addr] <= c_data;
      end
    end
  end

  // Frame FSM: fill the back bank, wait for commit, swap only at vblank
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      state      <= ST_ACCEPT;
      in_ready_q <= 1'b0;
      disp_bank  <= 1'b0;
      shown      <= 1'b0;
      swap_pulse <= 1'b0;
    end else begin
      swap_pulse <= 1'b0;
      case (state)
        ST_ACCEPT: begin
          if (accept && in_if.in_last) begin
            state      <= ST_DRAIN;
            in_ready_q <= 1'b0;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (c_valid && c_last) begin
            state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (vblank_start) begin
            state      <= ST_ACCEPT;
            in_ready_q <= 1'b1;
            disp_bank  <= ~disp_bank;
            shown      <= 1'b1;
            swap_pulse <= 1'b1;
          end
        end
        default: begin
          state      <= ST_ACCEPT;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Renderer read port: one-cycle latency, blank until the first swap
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (!shown || ({1'b0, rd_addr} >= BIN_LIMIT)) begin
      rd_data <= '0;
    end else if (disp_bank) begin
      rd_data <= bank1[rd_addr];
    end else begin
      rd_data <= bank0[rd_addr];
    end
  end

endmodule
